// File: rtl/vp_sequencer_if.sv
// Handshake bundle between the MEM-stage value-prediction sequencer and its pipeline neighbours.
// slave = sequencer side, master = pipeline/test side.
interface vp_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 16
);
  // Handshakes: ld_issue is taken only while pred_accept is high; recover_req and
  // out_lock are levels held until recover_done / out_lock_off; commit and
  // recover_ack are single-cycle pulses.
  logic                  ld_issue;
  logic [ADDR_WIDTH-1:0] ld_pc;
  logic [DATA_WIDTH-1:0] pred_value;
  logic                  pred_accept;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  commit;
  logic                  recover_req;
  logic [ADDR_WIDTH-1:0] recover_pc;
  logic [DATA_WIDTH-1:0] recover_value;
  logic                  recover_done;
  logic                  recover_ack;
  logic                  out_lock;
  logic                  out_lock_off;
  logic                  timeout_err;
  logic [STAT_WIDTH-1:0] stat_correct;
  logic [STAT_WIDTH-1:0] stat_mispredict;

  modport slave (
    input  ld_issue, ld_pc, pred_value, mem_valid, mem_data, recover_done, out_lock_off,
    output pred_accept, commit, recover_req, recover_pc, recover_value, recover_ack,
           out_lock, timeout_err, stat_correct, stat_mispredict
  );

  modport master (
    output ld_issue, ld_pc, pred_value, mem_valid, mem_data, recover_done, out_lock_off,
    input  pred_accept, commit, recover_req, recover_pc, recover_value, recover_ack,
           out_lock, timeout_err, stat_correct, stat_mispredict
  );
endinterface

// File: rtl/vp_sequencer.sv
// Load value-prediction sequencer: tracks one predicted load, verifies it against the
// D-cache response, and runs the recovery handshake (req -> done -> ack -> lock) on mismatch.
module vp_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STAT_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic               clk,
  input  logic               rst,
  vp_sequencer_if.slave      bus,
  output logic [2:0]         o_dbg_state
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_MEM = 3'd1,
    S_RECOVER  = 3'd2,
    S_ACK      = 3'd3,
    S_LOCK     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_load;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_timeout;
  logic                  w_match;

  logic [ADDR_WIDTH-1:0] r_pc_q;
  logic [DATA_WIDTH-1:0] r_pred_q;
  logic [TW-1:0]         r_timer;
  logic                  r_commit;
  logic [ADDR_WIDTH-1:0] r_recover_pc;
  logic [DATA_WIDTH-1:0] r_recover_value;
  logic                  r_timeout_err;
  logic [STAT_WIDTH-1:0] r_stat_correct;
  logic [STAT_WIDTH-1:0] r_stat_mispredict;

  assign w_match = (bus.mem_data == r_pred_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_hit     = 1'b0;
    w_miss    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ld_issue) begin
          w_load = 1'b1;
          w_next = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        // A response landing in the timeout cycle still wins over the timeout.
        if (bus.mem_valid) begin
          if (w_match) begin
            w_hit  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_miss = 1'b1;
            w_next = S_RECOVER;
          end
        end else if (r_timer == TIMER_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RECOVER: begin
        if (bus.recover_done) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        w_next = S_LOCK;
      end
      S_LOCK: begin
        if (bus.out_lock_off) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_q            <= '0;
      r_pred_q          <= '0;
      r_timer           <= '0;
      r_commit          <= 1'b0;
      r_recover_pc      <= '0;
      r_recover_value   <= '0;
      r_timeout_err     <= 1'b0;
      r_stat_correct    <= '0;
      r_stat_mispredict <= '0;
    end else begin
      r_commit <= w_hit;
      if (w_load) begin
        r_pc_q   <= bus.ld_pc;
        r_pred_q <= bus.pred_value;
        r_timer  <= '0;
      end else if (r_state == S_WAIT_MEM) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_miss) begin
        r_recover_pc    <= r_pc_q;
        r_recover_value <= bus.mem_data;
      end
      // Counters stick at all-ones instead of wrapping.
      if (w_hit && !(&r_stat_correct)) begin
        r_stat_correct <= r_stat_correct + 1'b1;
      end
      if (w_miss && !(&r_stat_mispredict)) begin
        r_stat_mispredict <= r_stat_mispredict + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.pred_accept     = (r_state == S_IDLE);
  assign bus.recover_req     = (r_state == S_RECOVER);
  assign bus.recover_ack     = (r_state == S_ACK);
  assign bus.out_lock        = (r_state == S_LOCK);
  assign bus.commit          = r_commit;
  assign bus.recover_pc      = r_recover_pc;
  assign bus.recover_value   = r_recover_value;
  assign bus.timeout_err     = r_timeout_err;
  assign bus.stat_correct    = r_stat_correct;
  assign bus.stat_mispredict = r_stat_mispredict;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_vp_sequencer.sv
// Directed bench for vp_sequencer: commit, full recovery handshake, timeout priority,
// async reset mid-recovery, counter saturation (STAT_WIDTH=2) and sticky timeout.
module tb_vp_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 64;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_MEM = 3'd1;
  localparam logic [2:0] S_RECOVER  = 3'd2;
  localparam logic [2:0] S_LOCK     = 3'd4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;

  vp_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) bus ();

  vp_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .STAT_WIDTH    (SW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] pred);
    bus.ld_issue   = 1'b1;
    bus.ld_pc      = pc;
    bus.pred_value = pred;
    step();
    bus.ld_issue   = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    bus.mem_valid = 1'b1;
    bus.mem_data  = data;
    step();
    bus.mem_valid = 1'b0;
  endtask

  // checker
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    bus.ld_issue      = 1'b0;
    bus.ld_pc         = '0;
    bus.pred_value    = '0;
    bus.mem_valid     = 1'b0;
    bus.mem_data      = '0;
    bus.recover_done  = 1'b0;
    bus.out_lock_off  = 1'b0;
    step();
    step();

    // reset state
    check_val("rst_accept",  32'(bus.pred_accept), 32'd1);
    check_val("rst_commit",  32'(bus.commit), 32'd0);
    check_val("rst_req",     32'(bus.recover_req), 32'd0);
    check_val("rst_ack",     32'(bus.recover_ack), 32'd0);
    check_val("rst_lock",    32'(bus.out_lock), 32'd0);
    check_val("rst_tmo",     32'(bus.timeout_err), 32'd0);
    check_val("rst_rpc",     bus.recover_pc, 32'd0);
    check_val("rst_rval",    bus.recover_value, 32'd0);
    check_val("rst_sc",      32'(bus.stat_correct), 32'd0);
    check_val("rst_sm",      32'(bus.stat_mispredict), 32'd0);
    check_val("rst_state",   32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    step();

    // correct prediction
    issue(32'h40, 32'h0);
    check_val("t1_accept_lo", 32'(bus.pred_accept), 32'd0);
    check_val("t1_state",     32'(dbg_state), 32'(S_WAIT_MEM));
    step();
    respond(32'h0);
    check_val("t1_commit",    32'(bus.commit), 32'd1);
    check_val("t1_accept_hi", 32'(bus.pred_accept), 32'd1);
    check_val("t1_sc",        32'(bus.stat_correct), 32'd1);
    check_val("t1_req",       32'(bus.recover_req), 32'd0);
    step();
    check_val("t1_commit_pulse", 32'(bus.commit), 32'd0);

    // mispredict with full handshake; mem_valid during RECOVER ignored
    issue(32'h40, 32'h0);
    respond(32'hDEADBEEF);
    check_val("t2_req",    32'(bus.recover_req), 32'd1);
    check_val("t2_rpc",    bus.recover_pc, 32'h40);
    check_val("t2_rval",   bus.recover_value, 32'hDEADBEEF);
    check_val("t2_sm",     32'(bus.stat_mispredict), 32'd1);
    check_val("t2_commit", 32'(bus.commit), 32'd0);
    step();
    respond(32'h1234);
    step();
    step();
    check_val("t2_req_hold", 32'(bus.recover_req), 32'd1);
    check_val("t2_rval_hold", bus.recover_value, 32'hDEADBEEF);
    check_val("t2_sm_hold",  32'(bus.stat_mispredict), 32'd1);
    bus.recover_done = 1'b1;
    step();
    bus.recover_done = 1'b0;
    check_val("t2_ack",     32'(bus.recover_ack), 32'd1);
    check_val("t2_lock_lo", 32'(bus.out_lock), 32'd0);
    step();
    check_val("t2_ack_pulse", 32'(bus.recover_ack), 32'd0);
    check_val("t2_lock",      32'(bus.out_lock), 32'd1);
    step();
    step();
    check_val("t2_lock_hold", 32'(bus.out_lock), 32'd1);
    bus.out_lock_off = 1'b1;
    step();
    bus.out_lock_off = 1'b0;
    check_val("t2_unlock", 32'(bus.out_lock), 32'd0);
    check_val("t2_idle",   32'(bus.pred_accept), 32'd1);

    // mismatch in the timeout cycle beats timeout; done in first RECOVER cycle; off in ACK ignored
    issue(32'hC0, 32'h5);
    for (int i = 0; i < TO - 1; i++) step();
    check_val("t3_state_wait", 32'(dbg_state), 32'(S_WAIT_MEM));
    check_val("t3_tmo_pre",    32'(bus.timeout_err), 32'd0);
    respond(32'h6);
    check_val("t3_req",  32'(bus.recover_req), 32'd1);
    check_val("t3_tmo",  32'(bus.timeout_err), 32'd0);
    check_val("t3_rpc",  bus.recover_pc, 32'hC0);
    check_val("t3_rval", bus.recover_value, 32'h6);
    check_val("t3_sm",   32'(bus.stat_mispredict), 32'd2);
    bus.recover_done = 1'b1;
    step();
    bus.recover_done = 1'b0;
    check_val("t3_ack", 32'(bus.recover_ack), 32'd1);
    bus.out_lock_off = 1'b1;
    step();
    bus.out_lock_off = 1'b0;
    check_val("t3_lock_after_ack", 32'(bus.out_lock), 32'd1);
    check_val("t3_state_lock",     32'(dbg_state), 32'(S_LOCK));
    step();
    check_val("t3_lock_hold", 32'(bus.out_lock), 32'd1);
    bus.out_lock_off = 1'b1;
    step();
    bus.out_lock_off = 1'b0;
    check_val("t3_idle", 32'(dbg_state), 32'(S_IDLE));

    // async reset while in RECOVER
    issue(32'h100, 32'h1);
    respond(32'h2);
    check_val("t4_req_pre", 32'(bus.recover_req), 32'd1);
    check_val("t4_sm_pre",  32'(bus.stat_mispredict), 32'd3);
    check_val("t4_state",   32'(dbg_state), 32'(S_RECOVER));
    #2;
    rst = 1'b1;
    #1;
    check_val("t4_req",    32'(bus.recover_req), 32'd0);
    check_val("t4_accept", 32'(bus.pred_accept), 32'd1);
    check_val("t4_ack",    32'(bus.recover_ack), 32'd0);
    check_val("t4_rpc",    bus.recover_pc, 32'd0);
    check_val("t4_rval",   bus.recover_value, 32'd0);
    check_val("t4_sm",     32'(bus.stat_mispredict), 32'd0);
    check_val("t4_sc",     32'(bus.stat_correct), 32'd0);
    step();
    rst = 1'b0;
    step();
    issue(32'h140, 32'h7);
    check_val("t4_accepted", 32'(bus.pred_accept), 32'd0);
    respond(32'h7);
    check_val("t4_commit", 32'(bus.commit), 32'd1);
    check_val("t4_sc1",    32'(bus.stat_correct), 32'd1);

    // saturation: back-to-back correct loads, 2-bit counter stops at 3
    for (int i = 0; i < 4; i++) begin
      issue(32'h200 + 32'(i * 4), 32'h55 + 32'(i));
      respond(32'h55 + 32'(i));
      check_val("t5_commit", 32'(bus.commit), 32'd1);
      check_val("t5_sc",     32'(bus.stat_correct), (i + 2 > 3) ? 32'd3 : 32'(i + 2));
    end

    // timeout: sticky error, no counter change, late response ignored
    issue(32'h80, 32'h11);
    for (int i = 0; i < TO - 1; i++) step();
    check_val("t6_tmo_pre", 32'(bus.timeout_err), 32'd0);
    step();
    check_val("t6_tmo",    32'(bus.timeout_err), 32'd1);
    check_val("t6_idle",   32'(dbg_state), 32'(S_IDLE));
    check_val("t6_commit", 32'(bus.commit), 32'd0);
    check_val("t6_sc",     32'(bus.stat_correct), 32'd3);
    check_val("t6_sm",     32'(bus.stat_mispredict), 32'd0);
    respond(32'h22);
    check_val("t6_late_commit", 32'(bus.commit), 32'd0);
    check_val("t6_late_req",    32'(bus.recover_req), 32'd0);
    check_val("t6_late_state",  32'(dbg_state), 32'(S_IDLE));
    check_val("t6_late_sm",     32'(bus.stat_mispredict), 32'd0);
    step();
    step();
    check_val("t6_tmo_sticky", 32'(bus.timeout_err), 32'd1);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vp_sequencer.md
# vp_sequencer

Control sequencer for the load value-prediction path in the MEM stage. It admits one predicted load at a time and holds its PC and predicted value. It compares the predicted value against the D-cache response and either commits or drives the pipeline recovery handshake: request, done, ack, then output lock. It also keeps saturating hit/mispredict counters and flags loads whose cache response never arrives.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT_MEM before abandoning a prediction; must be >= 2.
- STAT_WIDTH, 16: width of each statistics counter.

Ports (widths use `ADDR_WIDTH` / `DATA_WIDTH` from mips_core.svh):
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- ld_issue  in  1  predicted load enters MEM this cycle; sampled only in IDLE
- ld_pc  in  ADDR_WIDTH  PC of the issuing load
- pred_value  in  DATA_WIDTH  value predictor's guess for that load
- pred_accept  out  1  high only in IDLE; front end must not issue a predicted load while low
- mem_valid  in  1  D-cache read response valid
- mem_data  in  DATA_WIDTH  D-cache read data
- commit  out  1  one-cycle pulse: prediction verified correct
- recover_req  out  1  level; pipeline must squash and replay from recover_pc with recover_value
- recover_pc  out  ADDR_WIDTH  PC of the mispredicted load
- recover_value  out  DATA_WIDTH  true loaded value
- recover_done  in  1  pipeline finished squash/replay
- recover_ack  out  1  one-cycle pulse acknowledging recover_done
- out_lock  out  1  level; writeback must keep recover_value until released
- out_lock_off  in  1  pipeline releases the lock
- timeout_err  out  1  sticky; set on any WAIT_MEM timeout; cleared only by rst
- stat_correct  out  STAT_WIDTH  saturating count of correct predictions
- stat_mispredict  out  STAT_WIDTH  saturating count of mispredictions

## Operation
- States: IDLE, WAIT_MEM, RECOVER, ACK, LOCK, held in a registered state register.
- pred_accept, recover_req, recover_ack and out_lock decode from the state only (Moore).
- IDLE:
  - On ld_issue, latch ld_pc to pc_q and pred_value to pred_q, clear the timer, and go to WAIT_MEM.
  - mem_valid, recover_done and out_lock_off are ignored.
- WAIT_MEM: the timer increments each cycle.
  - mem_valid with mem_data == pred_q: pulse commit, increment stat_correct, go to IDLE.
  - mem_valid with mismatch: latch mem_data to recover_value and pc_q to recover_pc, increment stat_mispredict, go to RECOVER.
  - No mem_valid and timer == TIMEOUT_CYCLES-1: set timeout_err, go to IDLE with no commit and no counter change.
  - mem_valid in the timeout cycle takes priority over timeout.
- RECOVER: hold recover_req high. recover_done moves to ACK. A mem_valid here is ignored.
- ACK: recover_ack is high for exactly this cycle. Go unconditionally to LOCK; out_lock_off is ignored here.
- LOCK: hold out_lock high. out_lock_off moves to IDLE.
- recover_pc and recover_value keep their values until the next mismatch. pc_q and pred_q keep their values until the next accepted ld_issue.
- Counters saturate at all-ones and do not wrap.
- Full 32-bit equality compare; no masking for byte or half-word loads (the front end predicts full words only).

## Timing
- Reset state: IDLE.
  - pred_accept=1.
  - commit, recover_req, recover_ack, out_lock, timeout_err = 0.
  - recover_pc, recover_value, stats, timer, pc_q, pred_q = 0.
- rst asserted mid-operation (any state) returns to IDLE immediately. Pending recovery is dropped and no ack is issued.
- ld_issue at edge N: pred_accept low from N+1. mem_valid is sampled from edge N+1 onward.
- Correct path: mem_valid at edge M gives commit high in cycle M+1 and pred_accept high in cycle M+1. A new ld_issue can be accepted at edge M+1, so back-to-back correct loads take 2 cycles each at minimum.
- Mispredict: mem_valid at M gives recover_req high from M+1. recover_done at edge R gives recover_ack high in cycle R+1 and out_lock high from R+2. out_lock_off at edge L (L >= R+2) gives IDLE at L+1.
- recover_done asserted in the same cycle recover_req first rises is accepted.
- Timeout: with no response, timeout_err rises TIMEOUT_CYCLES cycles after the WAIT_MEM entry edge.

## Test plan
- Correct prediction: ld_issue pc=0x40, pred=0x0; mem_valid data=0x0 two cycles later -> one commit pulse, stat_correct=1, no recover_req, pred_accept returns high.
- Mispredict full handshake: pred=0x0, mem_data=0xDEADBEEF -> recover_req with recover_pc=0x40, recover_value=0xDEADBEEF. recover_done after 5 cycles -> one-cycle recover_ack, then out_lock held until out_lock_off, then IDLE; stat_mispredict=1.
- Timeout: ld_issue with no mem_valid for 64 cycles -> timeout_err set at cycle 64 and stays set, IDLE, counters unchanged. A late mem_valid in IDLE is ignored.
- Boundary priority: mem_valid (mismatch) in cycle 63 of WAIT_MEM -> RECOVER, timeout_err stays 0. out_lock_off asserted during ACK -> ignored; LOCK held until it is re-asserted.
- Reset mid-RECOVER: assert rst while recover_req=1 -> all outputs return to reset values asynchronously; the next ld_issue is accepted normally.
- Saturation with STAT_WIDTH=2: 5 correct predictions -> stat_correct=3.
